fixed_div: RTL and testbench

Sequential signed fixed-point divider: q = a / b on the team's `fixed` type (B=20 total bits, D=8 fractional bits).
- It is the inverse operation of fmul. It provides general division where fixed_recip_lte1's |x|<=1 restriction is unacceptable.
- It uses radix-2 restoring division on magnitudes, producing one quotient bit per cycle, with valid/ready handshakes on both sides.
- It sits beside the pipelined fixed_inv_sqrt and fixed_recip_lte1 units in the fixed-point math library.

---
 rtl/fixed_div_pkg.sv | 34 +++
 rtl/fixed_div_step.sv | 26 ++
 rtl/fixed_div.sv | 118 +++++++++++
 tb/tb_fixed_div.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fixed_div_pkg.sv
// Shared fixed-point package for the math library.
// `fixed` is a signed B-bit value with D fractional bits. Provides basic
// arithmetic helpers, saturation constants, the (B+1)-bit magnitude type
// used by the divider, and the divider FSM state encoding.
package fixed_div_pkg;
   localparam int B      = 20;
   localparam int D      = 8;
   localparam int N_ITER = B + D;

   typedef logic signed [B-1:0] fixed;
   // Holds |x| for any fixed x, including |-2^(B-1)|
   typedef logic [B:0] mag_t;

   localparam fixed FIXED_1       = fixed'(1 << D);
   localparam fixed FIXED_MAX     = 20'sh7FFFF;
   // Negative saturation is symmetric with FIXED_MAX, so 20'sh80000 never appears
   localparam fixed FIXED_MIN_SAT = 20'sh80001;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} div_state_t;

   function automatic fixed fadd(input fixed x, input fixed y);
      return x + y;
   endfunction

   function automatic fixed fsub(input fixed x, input fixed y);
      return x - y;
   endfunction

   function automatic fixed fmul(input fixed x, input fixed y);
      logic signed [2*B-1:0] p;
      p = (2*B)'(x) * (2*B)'(y);
      return fixed'(p >>> D);
   endfunction
endpackage

// File: rtl/fixed_div_step.sv
// One radix-2 restoring division step (combinational).
//   i_r    : current partial remainder
//   i_nbit : next numerator bit (MSB first)
//   i_d    : divisor magnitude
//   o_r    : updated partial remainder
//   o_q    : quotient bit produced by this step
module fixed_div_step
   import fixed_div_pkg::*;
(
   input  mag_t i_r,
   input  logic i_nbit,
   input  mag_t i_d,
   output mag_t o_r,
   output logic o_q
);
   // One extra bit so the shifted remainder never wraps before the compare
   logic [B+1:0] w_rs;
   logic [B+1:0] w_diff;
   logic         w_ge;

   assign w_rs   = {i_r, i_nbit};
   assign w_ge   = (w_rs >= {1'b0, i_d});
   assign w_diff = w_rs - {1'b0, i_d};
   assign o_r    = w_ge ? w_diff[B:0] : w_rs[B:0];
   assign o_q    = w_ge;
endmodule

// File: rtl/fixed_div.sv
// Sequential signed fixed-point divider, q = a / b, one quotient bit per cycle.
// Restoring division on magnitudes; result truncated toward zero and
// saturated to +/-FIXED_MAX. Divide-by-zero saturates by the sign of a.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   a_in, b_in, in_valid    : operands, accepted when in_valid && in_ready
//   in_ready                : high only while idle
//   q_out, out_valid        : registered quotient, held until out_ready
//   out_ready               : consumer accept
module fixed_div
   import fixed_div_pkg::*;
(
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic [B-1:0] a_in,
   input  logic [B-1:0] b_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [B-1:0] q_out,
   output logic         out_valid,
   input  logic         out_ready
);
   localparam int NUM_W = B + D + 1;
   localparam int IT_W  = $clog2(N_ITER);
   localparam logic [N_ITER-1:0] Q_MAX = N_ITER'((1 << (B-1)) - 1);

   div_state_t         r_state, w_state_nx;
   logic               r_sign, r_sign_a, r_zero, r_out_valid;
   mag_t               r_bmag, r_rem;
   mag_t               w_rem_nx, w_amag, w_bmag, w_aext, w_bext;
   logic [NUM_W-1:0]   r_num;
   logic [N_ITER-1:0]  r_quo;
   logic [IT_W-1:0]    r_iter;
   logic [B-1:0]       r_q, w_q_fix;
   logic               w_qbit;

   assign in_ready  = (r_state == S_IDLE);
   assign q_out     = r_q;
   assign out_valid = r_out_valid;

   // Sign-extend before negating so -2^(B-1) yields magnitude 2^(B-1)
   assign w_aext = {a_in[B-1], a_in};
   assign w_bext = {b_in[B-1], b_in};
   assign w_amag = a_in[B-1] ? -w_aext : w_aext;
   assign w_bmag = b_in[B-1] ? -w_bext : w_bext;

   fixed_div_step u_step (
      .i_r    (r_rem),
      .i_nbit (r_num[N_ITER-1]),
      .i_d    (r_bmag),
      .o_r    (w_rem_nx),
      .o_q    (w_qbit)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)      w_state_nx = S_DIV;
         S_DIV:   if (r_iter == '0)  w_state_nx = S_FIX;
         S_FIX:                      w_state_nx = S_DONE;
         S_DONE:  if (out_ready)     w_state_nx = S_IDLE;
         default:                    w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_q_fix = r_sign ? -r_quo[B-1:0] : r_quo[B-1:0];
      if (r_zero)
         w_q_fix = r_sign_a ? FIXED_MIN_SAT : FIXED_MAX;
      else if (r_quo > Q_MAX)
         w_q_fix = r_sign ? FIXED_MIN_SAT : FIXED_MAX;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sign      <= 1'b0;
         r_sign_a    <= 1'b0;
         r_zero      <= 1'b0;
         r_bmag      <= '0;
         r_rem       <= '0;
         r_num       <= '0;
         r_quo       <= '0;
         r_iter      <= '0;
         r_q         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_sign   <= a_in[B-1] ^ b_in[B-1];
               r_sign_a <= a_in[B-1];
               r_zero   <= (b_in == '0);
               r_bmag   <= w_bmag;
               r_num    <= NUM_W'(w_amag) << D;
               r_rem    <= '0;
               r_quo    <= '0;
               r_iter   <= IT_W'(N_ITER - 1);
            end
            // Runs even on divide-by-zero to keep latency constant
            S_DIV: begin
               r_rem <= w_rem_nx;
               r_quo <= {r_quo[N_ITER-2:0], w_qbit};
               r_num <= r_num << 1;
               if (r_iter != '0) r_iter <= r_iter - IT_W'(1);
            end
            S_FIX: begin
               r_q         <= w_q_fix;
               r_out_valid <= 1'b1;
            end
            S_DONE: if (out_ready) r_out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div: directed corner cases plus randomised
// operands against an integer-arithmetic reference model.
module tb_fixed_div;
   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [19:0] a_in, b_in;
   logic        in_valid, in_ready;
   logic [19:0] q_out;
   logic        out_valid, out_ready;

   int n_chk = 0;
   int n_err = 0;
   int n_ovl = 0;

   fixed_div dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_out     (q_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in)
      if (in_ready === 1'b1 && out_valid === 1'b1) n_ovl++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // q = trunc(a*256/b), saturated to +/-0x7FFFF; b==0 saturates by sign of a
   function automatic logic [19:0] model(input logic [19:0] a, input logic [19:0] b);
      logic signed [19:0] sa, sb;
      longint na, nb, q;
      logic [63:0] qv;
      sa = a; sb = b;
      na = sa; nb = sb;
      if (nb == 0) return (na < 0) ? 20'h80001 : 20'h7FFFF;
      q = (na * 256) / nb;
      if (q > 524287)  return 20'h7FFFF;
      if (q < -524287) return 20'h80001;
      qv = q;
      return qv[19:0];
   endfunction

   // Issue one operation from IDLE, optionally hold off out_ready, check result.
   task automatic op(input string tag, input logic [19:0] a, input logic [19:0] b,
                     input logic [19:0] exp, input int hold, input bit chk_lat);
      int lat, bad_ir, bad_hold;
      logic [19:0] q;
      out_ready = (hold == 0);
      a_in = a; b_in = b; in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      a_in = $urandom; b_in = $urandom;  // must not affect the operation
      lat = 0; bad_ir = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (in_ready !== 1'b0) bad_ir++;
         @(posedge clk_in); #1;
         lat++;
      end
      q = q_out;
      chk({tag, "_q"}, q, exp);
      if (chk_lat) begin
         chk({tag, "_lat"}, lat, 29);
         chk({tag, "_busy_ir"}, bad_ir, 0);
      end
      if (hold > 0) begin
         bad_hold = 0;
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a_in = $urandom; b_in = $urandom;
            @(posedge clk_in); #1;
            in_valid = 1'b0;
            if (out_valid !== 1'b1 || q_out !== q || in_ready !== 1'b0) bad_hold++;
         end
         chk({tag, "_hold"}, bad_hold, 0);
         out_ready = 1'b1;
      end
      @(posedge clk_in); #1;
      chk({tag, "_ov_drop"}, out_valid, 0);
      chk({tag, "_ir_rise"}, in_ready, 1);
   endtask

   initial begin
      int seen;
      logic [19:0] ra, rb;
      rst_in = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;
      chk("rst_q", q_out, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_ir", in_ready, 1);

      op("half",   20'h00100, 20'h00200, 20'h00080, 0, 1);
      op("neg2",   20'h00300, 20'hFFE80, 20'hFFE00, 0, 1);
      // -1/3 = -85.33/256, truncated toward zero to -85
      op("third",  20'hFFF00, 20'h00300, 20'hFFFAB, 0, 1);
      op("ovf_p",  20'h7FFFF, 20'h00001, 20'h7FFFF, 0, 1);
      op("ovf_n",  20'h80000, 20'h00001, 20'h80001, 0, 1);
      op("dz_neg", 20'hFFB00, 20'h00000, 20'h80001, 0, 1);
      op("dz_00",  20'h00000, 20'h00000, 20'h7FFFF, 0, 1);
      op("bp",     20'h00500, 20'h00200, 20'h00280, 10, 1);

      // abort mid-operation with reset
      a_in = 20'h00700; b_in = 20'h00100; in_valid = 1'b1;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk_in);
      #1 rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid === 1'b1) seen++;
         @(posedge clk_in); #1;
      end
      chk("abort_ov", seen, 0);
      chk("abort_ir", in_ready, 1);
      op("post_rst", 20'h00A00, 20'h00500, 20'h00200, 0, 1);

      for (int n = 0; n < 2000; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = '0;
            1:       rb = 20'($urandom_range(1, 15));
            2:       rb = -20'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         op("rnd", ra, rb, model(ra, rb), $urandom_range(0, 2), 0);
      end

      chk("overlap", n_ovl, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
